// File: rtl/usc_rv_mc_unit.sv
// RV32M multi-cycle multiply/divide unit: single-cycle multiply and divide
// special cases, 32-step restoring divider, result held until writeback.
module usc_rv_mc_unit #(
   parameter int MC_CTL_W = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                mc_op_vld_i,
   input  logic [MC_CTL_W-1:0] mc_op_ctl_i,
   input  logic [31:0]         mc_op_src0_i,
   input  logic [31:0]         mc_op_src1_i,
   output logic                mc_rdy_o,
   input  logic                mc_flush_i,
   output logic                mc_wb_vld_o,
   output logic [4:0]          mc_wb_rd_o,
   output logic [31:0]         mc_wb_data_o,
   input  logic                mc_wb_rdy_i
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      state, state_nxt;
   logic [2:0]  op_in, op_q;
   logic [4:0]  rd_in, rd_q;
   logic [31:0] a_q, b_q;
   logic [4:0]  cnt;
   logic        div_busy;
   logic [31:0] rem_q, dvd_q;
   logic [4:0]  wb_rd_q;
   logic [31:0] wb_data_q;

   logic        accept, fast_in;
   logic        sdiv, neg_q, neg_r, a_sgn, b_sgn, ge;
   logic [31:0] mag_a, mag_b, rem_nxt, dvd_nxt, div_res, mul_res;
   logic [32:0] rem_sh;
   logic [63:0] a_ext, b_ext, prod;

   assign op_in  = mc_op_ctl_i[2:0];
   assign rd_in  = mc_op_ctl_i[7:3];
   assign accept = (state == IDLE) && mc_op_vld_i && !mc_flush_i;

   // Multiplies, divide-by-zero and signed overflow all resolve in one MUL cycle
   assign fast_in = !op_in[2] || (mc_op_src1_i == '0) ||
                    (!op_in[0] && mc_op_src0_i == 32'h8000_0000 && mc_op_src1_i == '1);

   // Multiplier: operands extended to 64 bits so the modular product is exact
   assign a_sgn = !(op_q[1] && op_q[0]);
   assign b_sgn = !op_q[1];
   assign a_ext = (a_sgn && a_q[31]) ? {32'hFFFF_FFFF, a_q} : {32'h0, a_q};
   assign b_ext = (b_sgn && b_q[31]) ? {32'hFFFF_FFFF, b_q} : {32'h0, b_q};
   assign prod  = a_ext * b_ext;

   always_comb begin
      mul_res = '0;
      if (!op_q[2])
         mul_res = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
      else if (b_q == '0)
         mul_res = op_q[1] ? a_q : '1;
      else
         mul_res = op_q[1] ? '0 : 32'h8000_0000;
   end

   // Restoring divider on magnitudes; remainder after subtraction fits in 32 bits
   assign sdiv    = op_q[2] && !op_q[0];
   assign mag_a   = (sdiv && a_q[31]) ? -a_q : a_q;
   assign mag_b   = (sdiv && b_q[31]) ? -b_q : b_q;
   assign rem_sh  = {rem_q, dvd_q[31]};
   assign ge      = rem_sh >= {1'b0, mag_b};
   assign rem_nxt = ge ? (rem_sh[31:0] - mag_b) : rem_sh[31:0];
   assign dvd_nxt = {dvd_q[30:0], ge};
   assign neg_q   = sdiv && (a_q[31] ^ b_q[31]);
   assign neg_r   = sdiv && a_q[31];
   assign div_res = op_q[1] ? (neg_r ? -rem_nxt : rem_nxt)
                            : (neg_q ? -dvd_nxt : dvd_nxt);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (mc_flush_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (mc_op_vld_i) state_nxt = fast_in ? MUL : DIV;
            MUL:     state_nxt = DONE;
            DIV:     if (div_busy && cnt == 5'd31) state_nxt = DONE;
            DONE:    if (mc_wb_rdy_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      mc_rdy_o    = 1'b0;
      mc_wb_vld_o = 1'b0;
      case (state)
         IDLE:    mc_rdy_o    = 1'b1;
         DONE:    mc_wb_vld_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q      <= '0;
         rd_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         cnt       <= '0;
         div_busy  <= 1'b0;
         rem_q     <= '0;
         dvd_q     <= '0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         if (accept) begin
            op_q     <= op_in;
            rd_q     <= rd_in;
            a_q      <= mc_op_src0_i;
            b_q      <= mc_op_src1_i;
            cnt      <= '0;
            div_busy <= 1'b0;
         end
         if (state == MUL && !mc_flush_i) begin
            wb_data_q <= mul_res;
            wb_rd_q   <= rd_q;
         end
         // First DIV cycle loads magnitudes, then 32 iteration cycles follow
         if (state == DIV && !mc_flush_i) begin
            if (!div_busy) begin
               div_busy <= 1'b1;
               rem_q    <= '0;
               dvd_q    <= mag_a;
            end else begin
               rem_q <= rem_nxt;
               dvd_q <= dvd_nxt;
               cnt   <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  wb_data_q <= div_res;
                  wb_rd_q   <= rd_q;
               end
            end
         end
      end
   end

   assign mc_wb_rd_o   = wb_rd_q;
   assign mc_wb_data_o = wb_data_q;

endmodule

// File: tb/tb_usc_rv_mc_unit.sv
// Self-checking bench for usc_rv_mc_unit: directed RV32M corner cases plus
// randomized ops compared against an arithmetic reference model.
module tb_usc_rv_mc_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mc_op_vld_i = 1'b0;
   logic [7:0]  mc_op_ctl_i = '0;
   logic [31:0] mc_op_src0_i = '0;
   logic [31:0] mc_op_src1_i = '0;
   logic        mc_rdy_o;
   logic        mc_flush_i = 1'b0;
   logic        mc_wb_vld_o;
   logic [4:0]  mc_wb_rd_o;
   logic [31:0] mc_wb_data_o;
   logic        mc_wb_rdy_i = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   usc_rv_mc_unit #(.MC_CTL_W(8)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .mc_op_vld_i  (mc_op_vld_i),
      .mc_op_ctl_i  (mc_op_ctl_i),
      .mc_op_src0_i (mc_op_src0_i),
      .mc_op_src1_i (mc_op_src1_i),
      .mc_rdy_o     (mc_rdy_o),
      .mc_flush_i   (mc_flush_i),
      .mc_wb_vld_o  (mc_wb_vld_o),
      .mc_wb_rd_o   (mc_wb_rd_o),
      .mc_wb_data_o (mc_wb_data_o),
      .mc_wb_rdy_i  (mc_wb_rdy_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          p;
      longint unsigned u;
      int              sa, sb;
      logic            ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
         3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
         3'd2: begin p = longint'(sa) * longint'({32'h0, b}); return p[63:32]; end
         3'd3: begin u = {32'h0, a} * {32'h0, b}; return u[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op < 3'd4 || b == 0) return 2;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 34;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         4:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge with the unit idle; returns at a negedge with it idle again
   task automatic do_op(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data, input int exp_lat,
                        input int hold);
      int lat;
      check("rdy_idle", 32'(mc_rdy_o), 32'd1);
      mc_op_vld_i  = 1'b1;
      mc_op_ctl_i  = {rd, op};
      mc_op_src0_i = a;
      mc_op_src1_i = b;
      mc_wb_rdy_i  = (hold == 0);
      @(negedge clk);
      mc_op_vld_i = 1'b0;
      lat = 1;
      while (!mc_wb_vld_o && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("wb_data", mc_wb_data_o, exp_data);
      check("wb_rd", 32'(mc_wb_rd_o), 32'(rd));
      check("rdy_busy", 32'(mc_rdy_o), 32'd0);
      for (int i = 0; i < hold; i++) begin
         mc_op_vld_i  = 1'b1;
         mc_op_ctl_i  = 8'($urandom);
         mc_op_src0_i = $urandom;
         mc_op_src1_i = $urandom;
         @(negedge clk);
         check("hold_vld", 32'(mc_wb_vld_o), 32'd1);
         check("hold_data", mc_wb_data_o, exp_data);
         check("hold_rd", 32'(mc_wb_rd_o), 32'(rd));
         check("hold_rdy", 32'(mc_rdy_o), 32'd0);
      end
      mc_op_vld_i = 1'b0;
      mc_wb_rdy_i = 1'b1;
      @(negedge clk);
      mc_wb_rdy_i = 1'b0;
      check("post_vld", 32'(mc_wb_vld_o), 32'd0);
      check("post_rdy", 32'(mc_rdy_o), 32'd1);
      if (lat >= 60) begin
         mc_flush_i = 1'b1;
         @(negedge clk);
         mc_flush_i = 1'b0;
      end
   endtask

   task automatic watch_no_wb(input string tag);
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mc_wb_vld_o) seen++;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  op;
      logic [4:0]  rd;
      logic [31:0] a, b;

      repeat (3) @(negedge clk);
      check("rst_rdy", 32'(mc_rdy_o), 32'd1);
      check("rst_vld", 32'(mc_wb_vld_o), 32'd0);
      check("rst_rd", 32'(mc_wb_rd_o), 32'd0);
      check("rst_data", mc_wb_data_o, 32'd0);
      reset_n = 1'b1;

      // Directed RV32M corner cases
      do_op(3'd0, 5'd5, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 0);
      do_op(3'd3, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0);
      do_op(3'd4, 5'd1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 0);
      do_op(3'd6, 5'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 0);
      do_op(3'd5, 5'd3, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 2, 0);
      do_op(3'd6, 5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, 0);
      do_op(3'd4, 5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
      do_op(3'd7, 5'd7, 32'h0000_0055, 32'h0000_0000, 32'h0000_0055, 2, 0);
      do_op(3'd1, 5'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 5);

      // Flush in the middle of a divide
      check("fl_rdy0", 32'(mc_rdy_o), 32'd1);
      mc_op_vld_i = 1'b1; mc_op_ctl_i = {5'd8, 3'd4};
      mc_op_src0_i = 32'd100; mc_op_src1_i = 32'd7;
      @(negedge clk);
      mc_op_vld_i = 1'b0;
      repeat (9) @(negedge clk);
      check("fl_busy", 32'(mc_rdy_o), 32'd0);
      mc_flush_i = 1'b1;
      @(negedge clk);
      mc_flush_i = 1'b0;
      check("fl_rdy", 32'(mc_rdy_o), 32'd1);
      check("fl_vld", 32'(mc_wb_vld_o), 32'd0);
      watch_no_wb("fl_no_wb");

      // Flush coincident with a valid op
      mc_op_vld_i = 1'b1; mc_flush_i = 1'b1; mc_op_ctl_i = {5'd9, 3'd0};
      mc_op_src0_i = 32'd3; mc_op_src1_i = 32'd4;
      @(negedge clk);
      mc_op_vld_i = 1'b0; mc_flush_i = 1'b0;
      check("flc_rdy", 32'(mc_rdy_o), 32'd1);
      watch_no_wb("flc_no_wb");

      // Flush and writeback-ready together in DONE
      mc_op_vld_i = 1'b1; mc_op_ctl_i = {5'd10, 3'd0};
      mc_op_src0_i = 32'd6; mc_op_src1_i = 32'd7;
      @(negedge clk);
      mc_op_vld_i = 1'b0;
      @(negedge clk);
      check("fd_vld", 32'(mc_wb_vld_o), 32'd1);
      mc_flush_i = 1'b1; mc_wb_rdy_i = 1'b1;
      @(negedge clk);
      mc_flush_i = 1'b0; mc_wb_rdy_i = 1'b0;
      check("fd_vld_off", 32'(mc_wb_vld_o), 32'd0);
      check("fd_rdy", 32'(mc_rdy_o), 32'd1);

      // Reset in the middle of a divide, then a multiply right after release
      mc_op_vld_i = 1'b1; mc_op_ctl_i = {5'd11, 3'd5};
      mc_op_src0_i = 32'd1000; mc_op_src1_i = 32'd3;
      @(negedge clk);
      mc_op_vld_i = 1'b0;
      repeat (19) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("mr_rdy", 32'(mc_rdy_o), 32'd1);
      check("mr_vld", 32'(mc_wb_vld_o), 32'd0);
      check("mr_rd", 32'(mc_wb_rd_o), 32'd0);
      check("mr_data", mc_wb_data_o, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      do_op(3'd0, 5'd12, 32'd3, 32'd5, 32'd15, 2, 0);

      // Randomized ops against the reference model
      for (int n = 0; n < 120; n++) begin
         op = 3'($urandom_range(0, 7));
         rd = 5'($urandom);
         a  = pick_operand();
         b  = pick_operand();
         do_op(op, rd, a, b, ref_result(op, a, b), ref_latency(op, a, b), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
